// File: rtl/ring_game_pkg.sv
// ring_game_pkg: shared definitions for the ring game sequencer.
//   state_e     - FSM state encoding, also driven out for display/debug
//   TAP_IDX     - ring bit index of each of the NUM_POS positions
//   decode_pos  - maps a 15-bit ring value to {valid, position}
package ring_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned NUM_POS = 5;
  localparam int unsigned POS_W   = 15;
  localparam int unsigned TAP_IDX [NUM_POS] = '{0, 3, 6, 9, 12};

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pos_dec_t;

  // valid only when the ring value is exactly one set bit sitting on a tap.
  function automatic pos_dec_t decode_pos(input logic [POS_W-1:0] pos);
    pos_dec_t res;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int unsigned i = 0; i < NUM_POS; i++) begin
      if (pos == (POS_W'(1) << TAP_IDX[i])) begin
        res.valid = 1'b1;
        res.idx   = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_game_ctrl_if.sv
// ring_game_ctrl_if: signal bundle between the button/ring environment and
// the game controller.
//   btn_start, btn_hit - single-cycle button pulses
//   target, pos        - target position and current ring value
//   step, ring_rst     - ring step enable and ring reload pulses
//   score, lives, win, lose, state - game status
// master: environment side; slave: controller side.
interface ring_game_ctrl_if;
  import ring_game_pkg::*;

  logic             btn_start;
  logic             btn_hit;
  logic [2:0]       target;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             ring_rst;
  logic [3:0]       score;
  logic [1:0]       lives;
  logic             win;
  logic             lose;
  logic [2:0]       state;

  modport master (
    output btn_start, btn_hit, target, pos,
    input  step, ring_rst, score, lives, win, lose, state
  );

  modport slave (
    input  btn_start, btn_hit, target, pos,
    output step, ring_rst, score, lives, win, lose, state
  );

endinterface

// File: rtl/ring_game_ctrl_step_timer.sv
// step_timer: tick counter generating the ring step pulse.
//   clk, rst - clock, asynchronous active-high reset
//   clr_i    - force tick to zero
//   en_i     - count enable; when low tick holds and no step is produced
//   div_i    - cycles per step (>= 1)
//   step_o   - high for the enabled cycle in which tick reaches div_i-1
module step_timer #(
  parameter int unsigned DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             step_o
);

  logic [DIV_W-1:0] tick_q;
  logic             wrap;

  // >= rather than == so a shrinking div never leaves tick stranded above it.
  assign wrap   = (tick_q >= (div_i - DIV_W'(1)));
  assign step_o = en_i & wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
    end else if (clr_i) begin
      tick_q <= '0;
    end else if (en_i) begin
      tick_q <= wrap ? '0 : tick_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ring_game_ctrl.sv
// ring_game_ctrl: sequencer for the 15-bit one-hot position ring.
// Generates the speeding-up ring step, restarts the ring, judges hits
// against the target position and keeps score and lives.
//   clk   - system clock
//   rst_n - asynchronous reset, active-high despite the name
//   bus   - ring_game_ctrl_if.slave (buttons, target, pos in; step,
//           ring_rst, score, lives, win, lose, state out)
module ring_game_ctrl
  import ring_game_pkg::*;
#(
  parameter int unsigned DIV_W     = 27,
  parameter int unsigned BASE_DIV  = 50_000_000,
  parameter int unsigned MIN_DIV   = 5_000_000,
  parameter int unsigned DIV_DEC   = 5_000_000,
  parameter int unsigned WIN_SCORE = 8,
  parameter int unsigned LIVES     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  ring_game_ctrl_if.slave  bus
);

  state_e           state_q;
  logic [3:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic             win_q, lose_q, ring_rst_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W:0]   div_wide;
  logic [POS_W-1:0] pos_q;
  pos_dec_t         dec;
  logic             is_hit;
  logic             tmr_en, tmr_clr;

  // Timer runs only in RUN, and pauses for the cycle a button is seen so
  // the hit cycle neither steps the ring nor advances the phase.
  assign tmr_en  = (state_q == ST_RUN) && !bus.btn_start && !bus.btn_hit;
  assign tmr_clr = (state_q == ST_LOAD);

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .rst    (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .div_i  (div_q),
    .step_o (bus.step)
  );

  always_comb begin
    dec    = decode_pos(pos_q);
    is_hit = dec.valid && (dec.idx == bus.target);

    score_d = (score_q >= 4'(WIN_SCORE)) ? score_q : score_q + 4'd1;
    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

    // One extra bit so the borrow shows up instead of wrapping.
    div_wide = {1'b0, div_q} - (DIV_W+1)'(DIV_DEC);
    if (div_wide[DIV_W] || (div_wide[DIV_W-1:0] < DIV_W'(MIN_DIV)))
      div_d = DIV_W'(MIN_DIV);
    else
      div_d = div_wide[DIV_W-1:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      lives_q    <= 2'(LIVES);
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      div_q      <= DIV_W'(BASE_DIV);
      ring_rst_q <= 1'b0;
      pos_q      <= '0;
    end else begin
      ring_rst_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (bus.btn_start) begin
            state_q    <= ST_LOAD;
            ring_rst_q <= 1'b1;
            score_q    <= '0;
            lives_q    <= 2'(LIVES);
            div_q      <= DIV_W'(BASE_DIV);
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
          end else if (state_q == ST_RUN && bus.btn_hit) begin
            pos_q   <= bus.pos;
            state_q <= ST_CHECK;
          end
        end
        ST_LOAD: state_q <= ST_RUN;
        ST_CHECK: begin
          if (is_hit) begin
            score_q <= score_d;
            div_q   <= div_d;
            if (score_d == 4'(WIN_SCORE)) begin
              state_q <= ST_DONE;
              win_q   <= 1'b1;
            end else begin
              state_q    <= ST_LOAD;
              ring_rst_q <= 1'b1;
            end
          end else begin
            lives_q <= lives_d;
            if (lives_d == 2'd0) begin
              state_q <= ST_DONE;
              lose_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_DONE: if (bus.btn_start) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ring_rst = ring_rst_q;
  assign bus.score    = score_q;
  assign bus.lives    = lives_q;
  assign bus.win      = win_q;
  assign bus.lose     = lose_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_ring_game_ctrl.sv
// tb_ring_game_ctrl: directed test of ring_game_ctrl with small divider
// parameters (BASE_DIV=4, MIN_DIV=2, DIV_DEC=1, WIN_SCORE=3, LIVES=3).
module tb_ring_game_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;
  localparam int S_CHECK = 3;
  localparam int S_DONE  = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  ring_game_ctrl_if bus ();

  ring_game_ctrl #(
    .DIV_W     (8),
    .BASE_DIV  (4),
    .MIN_DIV   (2),
    .DIV_DEC   (1),
    .WIN_SCORE (3),
    .LIVES     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int want);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift the step output of n consecutive cycles into a word, first cycle MSB.
  task automatic step_pattern(input int n, output int pat);
    pat = 0;
    for (int i = 0; i < n; i++) begin
      pat = (pat << 1) | int'(bus.step);
      cyc(1);
    end
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
  endtask

  // Hit pressed in the current cycle; returns two cycles later (result visible).
  task automatic press_hit();
    bus.btn_hit = 1'b1;
    cyc(1);
    bus.btn_hit = 1'b0;
    cyc(1);
  endtask

  initial begin
    int pat;
    n_vec = 0;
    n_bad = 0;
    bus.btn_start = 1'b0;
    bus.btn_hit   = 1'b0;
    bus.target    = 3'd0;
    bus.pos       = 15'h0001;
    rst_n         = 1'b1;
    cyc(2);
    rst_n = 1'b0;

    // 1. reset values, start, step every 4th RUN cycle
    check_val("rst_state", int'(bus.state), S_IDLE);
    check_val("rst_score", int'(bus.score), 0);
    check_val("rst_lives", int'(bus.lives), 3);
    check_val("rst_winlose", int'({bus.win, bus.lose}), 0);
    check_val("rst_step_ringrst", int'({bus.step, bus.ring_rst}), 0);
    press_start();
    check_val("load_state", int'(bus.state), S_LOAD);
    check_val("load_ring_rst", int'(bus.ring_rst), 1);
    cyc(1);
    check_val("run_state", int'(bus.state), S_RUN);
    check_val("run_ring_rst_low", int'(bus.ring_rst), 0);
    step_pattern(8, pat);
    check_val("period4", pat, 'b00010001);

    // 2. three hits on position 1: period 3, then floor 2, then win
    bus.pos    = 15'h0008;
    bus.target = 3'd1;
    bus.btn_hit = 1'b1;
    cyc(1);
    bus.btn_hit = 1'b0;
    check_val("hit1_check_state", int'(bus.state), S_CHECK);
    check_val("hit1_score_not_yet", int'(bus.score), 0);
    cyc(1);
    check_val("hit1_score", int'(bus.score), 1);
    check_val("hit1_state", int'(bus.state), S_LOAD);
    check_val("hit1_ring_rst", int'(bus.ring_rst), 1);
    cyc(1);
    step_pattern(6, pat);
    check_val("period3", pat, 'b001001);
    press_hit();
    check_val("hit2_score", int'(bus.score), 2);
    cyc(1);
    step_pattern(6, pat);
    check_val("period2", pat, 'b010101);
    press_hit();
    check_val("win_state", int'(bus.state), S_DONE);
    check_val("win_score", int'(bus.score), 3);
    check_val("win_flags", int'({bus.win, bus.lose}), 2);
    step_pattern(4, pat);
    check_val("done_no_step", pat, 0);

    // 3. three misses with tick phase kept: lives 2,1,0 then lose
    press_start();
    check_val("done_to_idle", int'(bus.state), S_IDLE);
    press_start();
    check_val("restart_score", int'(bus.score), 0);
    check_val("restart_lives", int'(bus.lives), 3);
    check_val("restart_win_clr", int'(bus.win), 0);
    cyc(1);
    bus.pos    = 15'h0001;
    bus.target = 3'd2;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      press_hit();
      check_val("miss_lives", int'(bus.lives), 2 - i);
      check_val("miss_state", int'(bus.state), S_RUN);
      step_pattern(4, pat);
      check_val("miss_phase", pat, 'b0100);
    end
    press_hit();
    check_val("lose_state", int'(bus.state), S_DONE);
    check_val("lose_lives", int'(bus.lives), 0);
    check_val("lose_flags", int'({bus.win, bus.lose}), 1);
    step_pattern(4, pat);
    check_val("lose_no_step", pat, 0);

    // 4. two-bit pos and out-of-range target miss; hit on step boundary
    press_start();
    press_start();
    cyc(1);
    bus.pos    = 15'h0009;
    bus.target = 3'd0;
    press_hit();
    check_val("twobit_lives", int'(bus.lives), 2);
    check_val("twobit_score", int'(bus.score), 0);
    bus.pos    = 15'h0040;
    bus.target = 3'd6;
    press_hit();
    check_val("tgt6_lives", int'(bus.lives), 1);
    check_val("tgt6_state", int'(bus.state), S_RUN);
    bus.pos    = 15'h0200;
    bus.target = 3'd3;
    cyc(3);
    bus.btn_hit = 1'b1;
    #1;
    check_val("boundary_step_suppressed", int'(bus.step), 0);
    cyc(1);
    bus.btn_hit = 1'b0;
    bus.pos     = 15'h0001;
    cyc(1);
    check_val("boundary_score", int'(bus.score), 1);
    check_val("boundary_lives", int'(bus.lives), 1);
    check_val("boundary_state", int'(bus.state), S_LOAD);

    // 5. start and hit together in RUN: start wins
    cyc(1);
    bus.btn_start = 1'b1;
    bus.btn_hit   = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    bus.btn_hit   = 1'b0;
    check_val("both_state", int'(bus.state), S_LOAD);
    check_val("both_ring_rst", int'(bus.ring_rst), 1);
    check_val("both_score", int'(bus.score), 0);
    check_val("both_lives", int'(bus.lives), 3);
    cyc(1);
    check_val("both_run", int'(bus.state), S_RUN);

    // 6. asynchronous reset mid-RUN
    bus.pos    = 15'h0001;
    bus.target = 3'd4;
    press_hit();
    check_val("pre_rst_lives", int'(bus.lives), 2);
    cyc(2);
    #3 rst_n = 1'b1;
    #1;
    check_val("arst_state", int'(bus.state), S_IDLE);
    check_val("arst_lives", int'(bus.lives), 3);
    check_val("arst_step_ringrst", int'({bus.step, bus.ring_rst}), 0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    step_pattern(8, pat);
    check_val("post_rst_no_step", pat, 0);
    check_val("post_rst_state", int'(bus.state), S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
